present_shared_datapath: RTL and testbench
==========================================

PRESENT_SHARED_DATAPATH -- requirements
Module: present_shared_datapath

Interface
REQ-001 SHALL have parameter SBOX_LAT, default 2, latency in cycles of the external 3-share S-box pipeline (legal range 1..8).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports pt1/pt2/pt3  input  64 each  plaintext shares; sampled on start.
REQ-005 SHALL have ports rk1/rk2/rk3  input  64 each  current round-key shares; sampled in KEYADD and FINAL cycles.
REQ-006 SHALL have port start  input  1  begin encryption; honoured only in IDLE.
REQ-007 SHALL have port round_idx  output  6  round-key index (1..32) the external key schedule must present.
REQ-008 SHALL have ports sb_in1/sb_in2/sb_in3  output  4 each  nibble shares to the masked S-box.
REQ-009 SHALL have ports sb_out1/sb_out2/sb_out3  input  4 each  S-box output shares, SBOX_LAT cycles after the matching sb_in.
REQ-010 SHALL have ports busy and done  output  1 each  busy while not IDLE/DONE; done is a one-cycle pulse.
REQ-011 SHALL have ports ct1/ct2/ct3  output  64 each  ciphertext shares, valid from done until the next accepted start.

Function
REQ-012 States: IDLE, KEYADD, SBOX, PLAYER, FINAL, DONE.
REQ-013 IDLE with start=1: state shares <= pt shares, round <= 1, go to KEYADD; start ignored in every other state.
REQ-014 KEYADD (1 cycle): share s <= share s XOR rk s; round_idx = round; go to SBOX.
REQ-015 SBOX (16+SBOX_LAT cycles): feed cycles 0..15 drive nibble j (bits 4j+3:4j, nibble 0 first) of each share on sb_in; cycle j+SBOX_LAT captures sb_out shares into nibble j; sb_in = 0 outside feed cycles.
REQ-016 PLAYER (1 cycle): apply PRESENT bit permutation (bit i -> 16i mod 63, bit 63 fixed) independently to each share; if round=31 go to FINAL, else round+1 and go to KEYADD.
REQ-017 FINAL (1 cycle): round_idx = 32; XOR rk shares into state; go to DONE.
REQ-018 DONE (1 cycle): done=1, ct shares = state shares; return to IDLE.
REQ-019 Latency: done asserted 31*(18+SBOX_LAT)+1 rising edges after the edge that accepted start (621 for SBOX_LAT=2).
REQ-020 Every linear operation SHALL be share-local; no logic SHALL combine different share indices (masking/glitch-robustness requirement).
REQ-021 round_idx SHALL be 0 in IDLE and DONE; in SBOX/PLAYER it holds the current round.
REQ-022 ct shares SHALL hold their value through IDLE until a new start is accepted.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, all state/ct shares 0, round_idx 0, sb_in 0, busy 0, done 0, regardless of state.
REQ-024 Reset deassertion mid-encryption SHALL NOT resume; a fresh start is required.

Structure
REQ-025 Package present_shared_pkg SHALL hold the state enumeration, NUM_ROUNDS=31, NIBBLES=16 and the pLayer permutation function.
REQ-026 One sub-module present_player_share (64-bit pure permutation), instantiated once per share.
REQ-027 The masked S-box SHALL remain external; this block contains no nonlinear logic.

Verification
REQ-028 Reset: rst_n low -> all outputs 0, busy 0; rst_n high with start low -> remains IDLE.
REQ-029 Unshared check, SBOX_LAT=2, bench S-box/key-schedule model, pt2=pt3=0, key 0: pt 0 -> XOR of ct shares = 5579C1387B228445, done at edge 621.
REQ-030 Random masks, pt FFFFFFFFFFFFFFFF, key all-ones (PRESENT-80) -> XOR of ct shares = 3333DCD3213210D2 for 100 independent mask sets.
REQ-031 start pulsed during round 5 -> ignored; done timing and ciphertext unchanged.
REQ-032 rst_n pulsed low during round 10 SBOX -> IDLE, outputs 0 immediately; subsequent start yields correct ciphertext.
REQ-033 SBOX_LAT=4 -> done at edge 683; nibble capture alignment verified via ciphertext match.

Source files
------------

// File: rtl/present_shared_pkg.sv
// Shared definitions for the 3-share PRESENT round datapath: FSM states,
// round/nibble counts and the PRESENT bit permutation.
package present_shared_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEYADD,
    ST_SBOX,
    ST_PLAYER,
    ST_FINAL,
    ST_DONE
  } state_t;

  localparam int NUM_ROUNDS = 31;
  localparam int NIBBLES    = 16;
  localparam int SHARES     = 3;

  // PRESENT pLayer: bit i moves to position 16*i mod 63, bit 63 stays put.
  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    int dst;
    y = '0;
    for (int i = 0; i < 63; i++) begin
      dst = (16 * i) % 63;
      y[dst[5:0]] = x[i];
    end
    y[63] = x[63];
    return y;
  endfunction

endpackage

// File: rtl/present_player_share.sv
// Pure wiring permutation applied to one share; one copy per share keeps the
// linear layer strictly share-local.
module present_player_share
  import present_shared_pkg::*;
(
  input  logic [63:0] din,
  output logic [63:0] dout
);

  assign dout = p_layer(din);

endmodule

// File: rtl/present_shared_datapath.sv
// Control FSM and share-local linear datapath of a 3-share masked PRESENT
// encryption core. The nonlinear S-box lives outside: nibbles are streamed
// out one per cycle and the matching results come back SBOX_LAT cycles later.
// SBOX_LAT is expected in the range 1..8.
module present_shared_datapath
  import present_shared_pkg::*;
#(
  parameter int SBOX_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] pt1,
  input  logic [63:0] pt2,
  input  logic [63:0] pt3,
  input  logic [63:0] rk1,
  input  logic [63:0] rk2,
  input  logic [63:0] rk3,
  input  logic        start,
  output logic [5:0]  round_idx,
  output logic [3:0]  sb_in1,
  output logic [3:0]  sb_in2,
  output logic [3:0]  sb_in3,
  input  logic [3:0]  sb_out1,
  input  logic [3:0]  sb_out2,
  input  logic [3:0]  sb_out3,
  output logic        busy,
  output logic        done,
  output logic [63:0] ct1,
  output logic [63:0] ct2,
  output logic [63:0] ct3
);

  localparam logic [4:0] LAT5     = 5'(SBOX_LAT);
  localparam logic [4:0] SBOX_END = 5'(NIBBLES + SBOX_LAT - 1);

  state_t      state;
  logic [4:0]  cnt;
  logic        feeding;
  logic        capturing;
  logic [3:0]  feed_idx;
  logic [3:0]  cap_idx;

  logic [63:0] pt_s  [SHARES];
  logic [63:0] rk_s  [SHARES];
  logic [63:0] ct_s  [SHARES];
  logic [3:0]  sbo_s [SHARES];
  logic [3:0]  sbi_s [SHARES];

  assign pt_s[0]  = pt1;
  assign pt_s[1]  = pt2;
  assign pt_s[2]  = pt3;
  assign rk_s[0]  = rk1;
  assign rk_s[1]  = rk2;
  assign rk_s[2]  = rk3;
  assign sbo_s[0] = sb_out1;
  assign sbo_s[1] = sb_out2;
  assign sbo_s[2] = sb_out3;
  assign sb_in1   = sbi_s[0];
  assign sb_in2   = sbi_s[1];
  assign sb_in3   = sbi_s[2];
  assign ct1      = ct_s[0];
  assign ct2      = ct_s[1];
  assign ct3      = ct_s[2];

  // First 16 SBOX cycles stream nibbles out; results land SBOX_LAT cycles later.
  assign feeding   = (state == ST_SBOX) && (cnt < 5'd16);
  assign feed_idx  = cnt[3:0];
  assign capturing = (state == ST_SBOX) && (cnt >= LAT5);
  assign cap_idx   = 4'(cnt - LAT5);

  for (genvar s = 0; s < SHARES; s++) begin : g_share
    logic [63:0] sh;
    logic [63:0] sh_perm;
    logic [63:0] ct_q;

    present_player_share u_player (
      .din  (sh),
      .dout (sh_perm)
    );

    assign sbi_s[s] = feeding ? sh[{feed_idx, 2'b00} +: 4] : 4'h0;
    assign ct_s[s]  = ct_q;

    // Per-share state and ciphertext register; only ever mixes with its own key/S-box share.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sh   <= '0;
        ct_q <= '0;
      end else begin
        case (state)
          ST_IDLE:   if (start) sh <= pt_s[s];
          ST_KEYADD: sh <= sh ^ rk_s[s];
          ST_SBOX:   if (capturing) sh[{cap_idx, 2'b00} +: 4] <= sbo_s[s];
          ST_PLAYER: sh <= sh_perm;
          ST_FINAL: begin
            sh   <= sh ^ rk_s[s];
            ct_q <= sh ^ rk_s[s];
          end
          default: ;
        endcase
      end
    end
  end

  // Round sequencing with registered busy/done/round_idx outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      round_idx <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_KEYADD;
            round_idx <= 6'd1;
            busy      <= 1'b1;
          end
        end
        ST_KEYADD: begin
          state <= ST_SBOX;
          cnt   <= '0;
        end
        ST_SBOX: begin
          if (cnt == SBOX_END) state <= ST_PLAYER;
          else                 cnt   <= cnt + 5'd1;
        end
        ST_PLAYER: begin
          if (round_idx == 6'(NUM_ROUNDS)) begin
            state     <= ST_FINAL;
            round_idx <= 6'd32;
          end else begin
            state     <= ST_KEYADD;
            round_idx <= round_idx + 6'd1;
          end
        end
        ST_FINAL: begin
          state     <= ST_DONE;
          round_idx <= '0;
          busy      <= 1'b0;
          done      <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_present_shared_datapath.sv
// Bench for present_shared_datapath: two instances (S-box latency 2 and 4)
// run side by side against a masked S-box/key-schedule model and a plain
// PRESENT-80 reference.
module tb_present_shared_datapath;

  localparam int BUDGET = 800;

  typedef struct {
    logic [63:0] pt;
    logic [79:0] key;
    bit          masked;
    logic [63:0] exp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] pt1, pt2, pt3;
  logic [63:0] km_a, km_b;
  logic        use_masks;
  logic [63:0] rk_tab [64];

  logic [63:0] rk1 [2], rk2 [2], rk3 [2];
  logic [5:0]  round_idx [2];
  logic [3:0]  sb_in1 [2], sb_in2 [2], sb_in3 [2];
  logic [3:0]  sb_out1 [2], sb_out2 [2], sb_out3 [2];
  logic        busy [2], done [2];
  logic [63:0] ct1 [2], ct2 [2], ct3 [2];

  int n_checks;
  int n_fail;
  int exp_edge [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] sbox_f(input logic [3:0] x);
    logic [63:0] t;
    t = 64'hC56B90AD3EF84712;
    return t[(15 - int'(x)) * 4 +: 4];
  endfunction

  function automatic logic [79:0] next_key(input logic [79:0] k, input int r);
    logic [79:0] n;
    n = {k[18:0], k[79:19]};
    n[79:76] = sbox_f(n[79:76]);
    n[19:15] = n[19:15] ^ 5'(r);
    return n;
  endfunction

  function automatic logic [63:0] ref_encrypt(input logic [63:0] pt, input logic [79:0] key);
    logic [79:0] k;
    logic [63:0] s, t;
    int d;
    k = key;
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = sbox_f(s[4*n +: 4]);
      t = '0;
      for (int i = 0; i < 64; i++) begin
        d = (i == 63) ? 63 : (i * 16) % 63;
        t[d] = s[i];
      end
      s = t;
      k = next_key(k, r);
    end
    return s ^ k[79:16];
  endfunction

  function automatic logic [11:0] masked_sbox(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    logic [3:0] y, r1, r2;
    y  = sbox_f(a ^ b ^ c);
    r1 = use_masks ? 4'($urandom) : 4'h0;
    r2 = use_masks ? 4'($urandom) : 4'h0;
    return {y ^ r1 ^ r2, r1, r2};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LATG = (g == 0) ? 2 : 4;
    logic [11:0] pipe [4];

    assign rk1[g] = rk_tab[round_idx[g]] ^ km_a ^ km_b;
    assign rk2[g] = km_a;
    assign rk3[g] = km_b;

    always @(posedge clk) begin
      pipe[0] <= masked_sbox(sb_in1[g], sb_in2[g], sb_in3[g]);
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end

    assign {sb_out1[g], sb_out2[g], sb_out3[g]} = pipe[LATG-1];

    present_shared_datapath #(.SBOX_LAT(LATG)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pt1       (pt1),
      .pt2       (pt2),
      .pt3       (pt3),
      .rk1       (rk1[g]),
      .rk2       (rk2[g]),
      .rk3       (rk3[g]),
      .start     (start),
      .round_idx (round_idx[g]),
      .sb_in1    (sb_in1[g]),
      .sb_in2    (sb_in2[g]),
      .sb_in3    (sb_in3[g]),
      .sb_out1   (sb_out1[g]),
      .sb_out2   (sb_out2[g]),
      .sb_out3   (sb_out3[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .ct1       (ct1[g]),
      .ct2       (ct2[g]),
      .ct3       (ct3[g])
    );
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Start one encryption on both instances and collect done edge and ciphertext XOR.
  task automatic applyStimulus(input logic [63:0] pt, input logic [79:0] key, input bit poke5,
                               output logic [63:0] ctx0, output logic [63:0] ctx1,
                               output int e0, output int e1);
    logic [79:0] k;
    logic [63:0] m2, m3;
    bit poked;
    k = key;
    for (int r = 1; r <= 32; r++) begin
      rk_tab[r] = k[79:16];
      k = next_key(k, r);
    end
    @(negedge clk);
    m2   = use_masks ? {$urandom, $urandom} : 64'h0;
    m3   = use_masks ? {$urandom, $urandom} : 64'h0;
    km_a = use_masks ? {$urandom, $urandom} : 64'h0;
    km_b = use_masks ? {$urandom, $urandom} : 64'h0;
    pt1 = pt ^ m2 ^ m3;
    pt2 = m2;
    pt3 = m3;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput("round_idx_after_start_lat2", 64'(round_idx[0]), 64'd1);
    checkOutput("busy_after_start_lat4", 64'(busy[1]), 64'd1);
    e0 = 0;
    e1 = 0;
    ctx0 = '0;
    ctx1 = '0;
    poked = 1'b0;
    for (int c = 1; c <= BUDGET && (e0 == 0 || e1 == 0); c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done[0] && e0 == 0) begin
        e0 = c;
        ctx0 = ct1[0] ^ ct2[0] ^ ct3[0];
      end
      if (done[1] && e1 == 0) begin
        e1 = c;
        ctx1 = ct1[1] ^ ct2[1] ^ ct3[1];
      end
      if (start) start = 1'b0;
      else if (poke5 && !poked && round_idx[0] == 6'd5) begin
        start = 1'b1;
        poked = 1'b1;
      end
    end
    start = 1'b0;
  endtask

  task automatic runAndCheck(input string name, input logic [63:0] pt, input logic [79:0] key,
                             input logic [63:0] exp, input bit poke5);
    logic [63:0] c0, c1;
    int e0, e1;
    applyStimulus(pt, key, poke5, c0, c1, e0, e1);
    checkOutput($sformatf("%s_ct_lat2", name), c0, exp);
    checkOutput($sformatf("%s_ct_lat4", name), c1, exp);
    checkOutput($sformatf("%s_done_edge_lat2", name), 64'(e0), 64'(exp_edge[0]));
    checkOutput($sformatf("%s_done_edge_lat4", name), 64'(e1), 64'(exp_edge[1]));
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checkOutput($sformatf("%s_done_low_%0d", name, g), 64'(done[g]), 64'd0);
      checkOutput($sformatf("%s_busy_low_%0d", name, g), 64'(busy[g]), 64'd0);
      checkOutput($sformatf("%s_round_idx_idle_%0d", name, g), 64'(round_idx[g]), 64'd0);
    end
    checkOutput($sformatf("%s_ct_held_lat2", name), ct1[0] ^ ct2[0] ^ ct3[0], exp);
    checkOutput($sformatf("%s_ct_held_lat4", name), ct1[1] ^ ct2[1] ^ ct3[1], exp);
  endtask

  // Everything an asserted reset must force to zero, on both instances.
  task automatic checkResetOutputs(input string name);
    for (int g = 0; g < 2; g++) begin
      checkOutput($sformatf("%s_busy_%0d", name, g), 64'(busy[g]), 64'd0);
      checkOutput($sformatf("%s_done_%0d", name, g), 64'(done[g]), 64'd0);
      checkOutput($sformatf("%s_round_idx_%0d", name, g), 64'(round_idx[g]), 64'd0);
      checkOutput($sformatf("%s_sb_in_%0d", name, g), 64'({sb_in1[g], sb_in2[g], sb_in3[g]}), 64'd0);
      checkOutput($sformatf("%s_ct_%0d", name, g), ct1[g] | ct2[g] | ct3[g], 64'd0);
    end
  endtask

  initial begin
    vec_t vecs [4];
    logic [63:0] rpt;
    logic [79:0] rkey;
    bit reached;

    n_checks = 0;
    n_fail   = 0;
    for (int g = 0; g < 2; g++) exp_edge[g] = 31 * (18 + ((g == 0) ? 2 : 4)) + 1;

    vecs[0] = '{pt: 64'h0,                key: 80'h0,                     masked: 1'b0, exp: 64'h5579C1387B228445};
    vecs[1] = '{pt: 64'h0,                key: 80'hFFFFFFFFFFFFFFFFFFFF,  masked: 1'b1, exp: 64'hE72C46C0F5945049};
    vecs[2] = '{pt: 64'hFFFFFFFFFFFFFFFF, key: 80'h0,                     masked: 1'b1, exp: 64'hA112FFC72F68417B};
    vecs[3] = '{pt: 64'hFFFFFFFFFFFFFFFF, key: 80'hFFFFFFFFFFFFFFFFFFFF,  masked: 1'b1, exp: 64'h3333DCD3213210D2};

    rst_n = 1'b0;
    start = 1'b0;
    pt1 = '0; pt2 = '0; pt3 = '0;
    km_a = '0; km_b = '0;
    use_masks = 1'b0;
    for (int i = 0; i < 64; i++) rk_tab[i] = '0;

    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checkOutput($sformatf("idle_busy_%0d", g), 64'(busy[g]), 64'd0);
      checkOutput($sformatf("idle_round_idx_%0d", g), 64'(round_idx[g]), 64'd0);
    end

    $display("[TB] known-answer vectors");
    for (int v = 0; v < 4; v++) begin
      use_masks = vecs[v].masked;
      runAndCheck($sformatf("kat%0d", v), vecs[v].pt, vecs[v].key, vecs[v].exp, 1'b0);
    end

    $display("[TB] 100 random mask sets, all-ones pt and key");
    use_masks = 1'b1;
    for (int i = 0; i < 100; i++)
      runAndCheck($sformatf("mask%0d", i), 64'hFFFFFFFFFFFFFFFF, 80'hFFFFFFFFFFFFFFFFFFFF,
                  64'h3333DCD3213210D2, 1'b0);

    $display("[TB] random plaintext/key against reference model");
    for (int i = 0; i < 3; i++) begin
      rpt  = {$urandom, $urandom};
      rkey = 80'({$urandom, $urandom, $urandom});
      runAndCheck($sformatf("rand%0d", i), rpt, rkey, ref_encrypt(rpt, rkey), 1'b0);
    end

    $display("[TB] start pulsed during round 5");
    rpt  = {$urandom, $urandom};
    rkey = 80'({$urandom, $urandom, $urandom});
    runAndCheck("start_poke", rpt, rkey, ref_encrypt(rpt, rkey), 1'b1);

    $display("[TB] reset during round 10");
    @(negedge clk);
    pt1 = {$urandom, $urandom};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < BUDGET && !reached; c++) begin
      @(negedge clk);
      if (round_idx[0] == 6'd10) reached = 1'b1;
    end
    checkOutput("reach_round10", 64'(reached), 64'd1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midreset_no_resume_lat2", 64'(busy[0]), 64'd0);
    checkOutput("midreset_no_resume_lat4", 64'(busy[1]), 64'd0);
    rpt  = {$urandom, $urandom};
    rkey = 80'({$urandom, $urandom, $urandom});
    runAndCheck("after_reset", rpt, rkey, ref_encrypt(rpt, rkey), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
